// File: rtl/dg_ddr_writer.sv
// -----------------------------------------------------------------------------
// dg_ddr_writer
//
// Write-back stage that sits behind the result/mask formatter. It accepts a
// single DDR_W-wide beat stream, buffers it in a first-word-fall-through FIFO
// and emits DDR write bursts (AW / W / B channels) at consecutive addresses
// starting from a configured base. `done` is raised only once every issued
// burst has been acknowledged on the B channel.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start                      one-cycle pulse, latches config when idle
//   done                       high while idle / after the last B response
//   err                        sticky, set by any nonzero b_resp, cleared on start
//   conf_base_addr             first byte address (BEAT_BYTES aligned)
//   conf_beat_num              total beats to transfer (>= 1)
//   conf_burst_len             beats per full burst (1..min(FIFO_DEPTH,255))
//   s_data/s_valid/s_ready     input beat stream
//   aw_addr/aw_len/aw_valid/aw_ready   write address channel
//   w_data/w_last/w_valid/w_ready      write data channel
//   b_resp/b_valid/b_ready             write response channel
// -----------------------------------------------------------------------------
module dg_ddr_writer #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 32,
    parameter int MAX_OUT    = 4,
    parameter int DDR_W      = 64,
    parameter int BEAT_BYTES = DDR_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    output logic              done,
    output logic              err,

    input  logic [ADDR_W-1:0] conf_base_addr,
    input  logic [15:0]       conf_beat_num,
    input  logic [7:0]        conf_burst_len,

    input  logic [DDR_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,

    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic              aw_valid,
    input  logic              aw_ready,

    output logic [DDR_W-1:0]  w_data,
    output logic              w_last,
    output logic              w_valid,
    input  logic              w_ready,

    input  logic [1:0]        b_resp,
    input  logic              b_valid,
    output logic              b_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State and register declarations
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;

    logic [15:0]       beat_num_q, beat_num_d;
    logic [7:0]        burst_len_q, burst_len_d;
    logic [15:0]       remaining_q, remaining_d;   // beats not yet covered by a finished burst
    logic [15:0]       accepted_q, accepted_d;     // beats taken from the input stream
    logic [7:0]        beat_cnt_q, beat_cnt_d;     // beat index inside the current burst
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;

    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              w_last_q, w_last_d;
    logic              b_ready_q, b_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // FIFO
    logic [DDR_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic              fifo_full;

    // Handshakes and helpers
    logic              start_go;
    logic              push;
    logic              pop;
    logic              aw_hs;
    logic              b_hs;
    logic [15:0]       burst_len_16;
    logic [15:0]       cur_len;
    logic [15:0]       burst_beats;
    logic [15:0]       rem_after;
    logic [ADDR_W-1:0] burst_bytes;
    logic              fill_ok;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign start_go  = start && (state_q == ST_IDLE);
    assign fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign s_ready   = !fifo_full && (accepted_q < beat_num_q) && (state_q != ST_IDLE);
    assign push      = s_valid && s_ready;
    assign pop       = w_valid_q && w_ready;
    assign aw_hs     = aw_valid_q && aw_ready;
    assign b_hs      = b_valid && b_ready_q;

    // Length of the burst about to be issued: a full burst, or the tail.
    assign burst_len_16 = {8'd0, burst_len_q};
    assign cur_len      = (remaining_q < burst_len_16) ? remaining_q : burst_len_16;

    // Length of the burst currently on the W channel, and what is left after it.
    assign burst_beats  = {8'd0, aw_len_q} + 16'd1;
    assign rem_after    = remaining_q - burst_beats;
    assign burst_bytes  = ADDR_W'(burst_beats) * ADDR_W'(BEAT_BYTES);

    // A whole burst must be buffered before its address goes out, so the W
    // channel never stalls on an empty FIFO once DATA is entered.
    assign fill_ok = (32'(fifo_cnt_q) >= 32'(cur_len)) &&
                     (outstanding_q < OUT_W'(MAX_OUT));

    // -------------------------------------------------------------------------
    // FIFO storage: array write, first-word-fall-through read of the head
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= s_data;
        end
    end

    assign w_data = fifo_mem[rd_ptr_q];

    // FIFO pointers, occupancy and accepted-beat counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        accepted_d = accepted_q;

        if (start_go) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            accepted_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                accepted_d = accepted_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outstanding write responses and sticky error
    // -------------------------------------------------------------------------
    always_comb begin
        outstanding_d = outstanding_q;
        if (aw_hs && !b_hs) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!aw_hs && b_hs && (outstanding_q != '0)) begin
            // A stray response with nothing outstanding is ignored rather
            // than allowed to wrap the counter.
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (start_go) begin
            err_d = 1'b0;
        end else if (b_hs && (b_resp != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state and datapath updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_num_d  = beat_num_q;
        burst_len_d = burst_len_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    beat_num_d  = conf_beat_num;
                    burst_len_d = conf_burst_len;
                    remaining_d = conf_beat_num;
                    aw_addr_d   = conf_base_addr;
                end
            end

            ST_FILL: begin
                if (fill_ok) begin
                    state_d    = ST_ADDR;
                    aw_len_d   = 8'(cur_len - 16'd1);
                    beat_cnt_d = 8'd0;
                end
            end

            ST_ADDR: begin
                if (aw_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (pop) begin
                    if (beat_cnt_q == aw_len_q) begin
                        remaining_d = rem_after;
                        if (rem_after == 16'd0) begin
                            state_d = ST_RESP;
                        end else begin
                            // Address arithmetic wraps naturally at ADDR_W.
                            aw_addr_d = aw_addr_q + burst_bytes;
                            state_d   = ST_FILL;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end

            ST_RESP: begin
                // Looking at the next-cycle count lets done rise on the cycle
                // right after the final B handshake.
                if (outstanding_d == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state
    always_comb begin
        aw_valid_d = (state_d == ST_ADDR);
        w_valid_d  = (state_d == ST_DATA);
        w_last_d   = (state_d == ST_DATA) && (beat_cnt_d == aw_len_d);
        b_ready_d  = (state_d != ST_IDLE);
        done_d     = (state_d == ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_num_q    <= 16'd0;
            burst_len_q   <= 8'd0;
            remaining_q   <= 16'd0;
            accepted_q    <= 16'd0;
            beat_cnt_q    <= 8'd0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            aw_addr_q     <= '0;
            aw_len_q      <= 8'd0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            w_last_q      <= 1'b0;
            b_ready_q     <= 1'b0;
            done_q        <= 1'b1;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_num_q    <= beat_num_d;
            burst_len_q   <= burst_len_d;
            remaining_q   <= remaining_d;
            accepted_q    <= accepted_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            aw_addr_q     <= aw_addr_d;
            aw_len_q      <= aw_len_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            w_last_q      <= w_last_d;
            b_ready_q     <= b_ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign aw_addr  = aw_addr_q;
    assign aw_len   = aw_len_q;
    assign aw_valid = aw_valid_q;
    assign w_valid  = w_valid_q;
    assign w_last   = w_last_q;
    assign b_ready  = b_ready_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dg_ddr_writer.sv
// -----------------------------------------------------------------------------
// tb_dg_ddr_writer
//
// Randomized bench for dg_ddr_writer. A bus process drives the stream source,
// the AW/W sinks and a B responder, and checks every handshake against a
// reference built from the configuration: a list of expected bursts
// (address, length), the queue of accepted input words, and simple counters.
// -----------------------------------------------------------------------------
module tb_dg_ddr_writer;

    localparam int FIFO_DEPTH = 64;
    localparam int ADDR_W     = 32;
    localparam int MAX_OUT    = 4;
    localparam int DDR_W      = 64;
    localparam int BB         = DDR_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] conf_base_addr = '0;
    logic [15:0]       conf_beat_num = '0;
    logic [7:0]        conf_burst_len = '0;
    logic [DDR_W-1:0]  s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic              aw_valid;
    logic              aw_ready;
    logic [DDR_W-1:0]  w_data;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;

    always #5 clk = ~clk;

    dg_ddr_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .MAX_OUT    (MAX_OUT),
        .DDR_W      (DDR_W),
        .BEAT_BYTES (BB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .err            (err),
        .conf_base_addr (conf_base_addr),
        .conf_beat_num  (conf_beat_num),
        .conf_burst_len (conf_burst_len),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .aw_addr        (aw_addr),
        .aw_len         (aw_len),
        .aw_valid       (aw_valid),
        .aw_ready       (aw_ready),
        .w_data         (w_data),
        .w_last         (w_last),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .b_resp         (b_resp),
        .b_valid        (b_valid),
        .b_ready        (b_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [ADDR_W-1:0] exp_aw_addr[$];
    logic [7:0]        exp_aw_len[$];
    int                w_len_q[$];
    logic [DDR_W-1:0]  exp_data[$];
    int beats_cfg = 0, total_bursts = 0;
    int acc_cnt = 0, w_cnt = 0, aw_cnt = 0, b_cnt = 0, pending_b = 0, w_in_burst = 0;
    int b_budget = -1, err_inject = 0;
    int p_s = 100, p_aw = 100, p_w = 100, p_b = 100;
    bit active = 0, final_b_prev = 0, err_model = 0, aw_wait = 0;
    logic [ADDR_W-1:0] aw_prev_addr = '0;
    logic [7:0]        aw_prev_len = '0;

    task automatic clear_model();
        exp_aw_addr.delete(); exp_aw_len.delete(); w_len_q.delete(); exp_data.delete();
        acc_cnt = 0; w_cnt = 0; aw_cnt = 0; b_cnt = 0; pending_b = 0; w_in_burst = 0;
        active = 0; final_b_prev = 0; err_model = 0; aw_wait = 0;
    endtask

    // Expected bursts: full bursts of `burst` beats, last one holding the remainder.
    task automatic build_model(input logic [ADDR_W-1:0] base, input int beats, input int burst);
        logic [ADDR_W-1:0] addr;
        int rem, len;
        exp_aw_addr.delete(); exp_aw_len.delete(); w_len_q.delete(); exp_data.delete();
        addr = base;
        rem  = beats;
        while (rem > 0) begin
            len = (rem < burst) ? rem : burst;
            exp_aw_addr.push_back(addr);
            exp_aw_len.push_back(8'(len - 1));
            w_len_q.push_back(len);
            addr = addr + ADDR_W'(len * BB);
            rem  = rem - len;
        end
        beats_cfg    = beats;
        total_bursts = w_len_q.size();
        acc_cnt = 0; w_cnt = 0; aw_cnt = 0; b_cnt = 0; pending_b = 0; w_in_burst = 0;
        final_b_prev = 0; aw_wait = 0;
    endtask

    // Observe one cycle (called at negedge; signals are stable here).
    task automatic monitor();
        bit hs_s, hs_aw, hs_w, hs_b;
        hs_s  = s_valid && s_ready;
        hs_aw = aw_valid && aw_ready;
        hs_w  = w_valid && w_ready;
        hs_b  = b_valid && b_ready;

        check_eq("err", 64'(err), 64'(err_model));
        check_eq("w_last_without_valid", 64'(w_last && !w_valid), 64'd0);
        if (active) begin
            check_eq("done", 64'(done), 64'(final_b_prev));
            if (done) active = 0;
            check_eq("s_ready_legal",
                     64'(s_ready && ((acc_cnt >= beats_cfg) || (acc_cnt - w_cnt >= FIFO_DEPTH))), 64'd0);
        end else begin
            check_eq("idle_s_ready", 64'(s_ready), 64'd0);
            check_eq("idle_b_ready", 64'(b_ready), 64'd0);
        end
        final_b_prev = 0;

        if (aw_wait) begin
            check_eq("aw_valid_held", 64'(aw_valid), 64'd1);
            check_eq("aw_addr_stable", 64'(aw_addr), 64'(aw_prev_addr));
            check_eq("aw_len_stable", 64'(aw_len), 64'(aw_prev_len));
        end
        aw_wait      = aw_valid && !aw_ready;
        aw_prev_addr = aw_addr;
        aw_prev_len  = aw_len;

        if (hs_aw) begin
            if (exp_aw_addr.size() == 0) begin
                check_eq("aw_unexpected", 64'd1, 64'd0);
            end else begin
                check_eq("aw_addr", 64'(aw_addr), 64'(exp_aw_addr.pop_front()));
                check_eq("aw_len", 64'(aw_len), 64'(exp_aw_len.pop_front()));
            end
            aw_cnt++;
            check_eq("aw_outstanding_limit", 64'((aw_cnt - b_cnt) <= MAX_OUT), 64'd1);
        end

        if (hs_w) begin
            if (exp_data.size() == 0) check_eq("w_unexpected", 64'd1, 64'd0);
            else                      check_eq("w_data", w_data, exp_data.pop_front());
            w_cnt++;
            w_in_burst++;
            if (w_len_q.size() > 0) begin
                check_eq("w_last", 64'(w_last), 64'(w_in_burst == w_len_q[0]));
                if (w_in_burst == w_len_q[0]) begin
                    void'(w_len_q.pop_front());
                    w_in_burst = 0;
                    pending_b++;
                end
            end
        end

        if (hs_s) begin
            exp_data.push_back(s_data);
            acc_cnt++;
        end

        if (hs_b) begin
            if (b_resp != 2'b00) begin
                err_model = 1;
                if (err_inject > 0) err_inject--;
            end
            if (b_budget > 0) b_budget--;
            if (pending_b > 0) pending_b--;
            b_cnt++;
            if (active && (b_cnt == total_bursts)) final_b_prev = 1;
        end
    endtask

    // Bus process: observe at negedge, drive 1 time unit after posedge.
    initial begin
        s_valid = 0; s_data = '0; aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) clear_model();
            else     monitor();
            @(posedge clk);
            #1;
            s_valid  = ($urandom_range(99) < p_s);
            s_data   = {$urandom, $urandom};
            aw_ready = ($urandom_range(99) < p_aw);
            w_ready  = ($urandom_range(99) < p_w);
            b_valid  = (pending_b > 0) && (b_budget != 0) && ($urandom_range(99) < p_b);
            b_resp   = (b_valid && (err_inject > 0)) ? 2'd2 : 2'd0;
        end
    end

    // ---------------- main sequence ----------------
    task automatic check_reset_values(input string tag);
        check_eq({tag, "_done"},     64'(done),     64'd1);
        check_eq({tag, "_err"},      64'(err),      64'd0);
        check_eq({tag, "_s_ready"},  64'(s_ready),  64'd0);
        check_eq({tag, "_aw_valid"}, 64'(aw_valid), 64'd0);
        check_eq({tag, "_w_valid"},  64'(w_valid),  64'd0);
        check_eq({tag, "_w_last"},   64'(w_last),   64'd0);
        check_eq({tag, "_b_ready"},  64'(b_ready),  64'd0);
        check_eq({tag, "_aw_addr"},  64'(aw_addr),  64'd0);
        check_eq({tag, "_aw_len"},   64'(aw_len),   64'd0);
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] base, input int beats, input int burst);
        @(posedge clk);
        #1;
        build_model(base, beats, burst);
        conf_base_addr = base;
        conf_beat_num  = 16'(beats);
        conf_burst_len = 8'(burst);
        start = 1;
        @(posedge clk);
        #1;
        start     = 0;
        err_model = 0;
        active    = 1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (active && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_finished_in_time"}, 64'(active), 64'd0);
        active = 0;
        check_eq({tag, "_aw_all_issued"}, 64'(exp_aw_addr.size()), 64'd0);
        check_eq({tag, "_data_all_written"}, 64'(exp_data.size()), 64'd0);
        check_eq({tag, "_accepted"}, 64'(acc_cnt), 64'(beats_cfg));
        check_eq({tag, "_w_beats"}, 64'(w_cnt), 64'(beats_cfg));
        check_eq({tag, "_b_count"}, 64'(b_cnt), 64'(total_bursts));
        $display("xfer %s: beats=%0d bursts=%0d aw=%0d w=%0d b=%0d cycles=%0d err=%0b",
                 tag, beats_cfg, total_bursts, aw_cnt, w_cnt, b_cnt, n, err);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [ADDR_W-1:0] base;
        int beats, burst;

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        #1;
        check_reset_values("por");

        // Basic transfer
        p_s = 100; p_aw = 100; p_w = 100; p_b = 100; b_budget = -1;
        start_xfer(32'h0000_1000, 16, 8);
        wait_done("basic", 500);

        // Short tail; source keeps offering beyond the 10th beat
        start_xfer(32'h0002_0040, 10, 4);
        wait_done("short_tail", 500);
        wait_cycles(8);
        check_eq("short_tail_no_11th", 64'(acc_cnt), 64'd10);

        // Backpressure
        p_s = 60; p_aw = 40; p_w = 50; p_b = 50;
        start_xfer(32'h0010_0000, 64, 16);
        wait_done("backpressure", 4000);

        // Response throttling
        p_s = 100; p_aw = 100; p_w = 100; p_b = 100; b_budget = 0;
        start_xfer(32'h0000_8000, 80, 16);
        n = 0;
        while ((aw_cnt < 4) && (n < 2000)) begin wait_cycles(1); n++; end
        check_eq("thr_four_aw", 64'(aw_cnt), 64'd4);
        wait_cycles(40);
        check_eq("thr_stall_aw_cnt", 64'(aw_cnt), 64'd4);
        check_eq("thr_stall_aw_valid", 64'(aw_valid), 64'd0);
        check_eq("thr_stall_done", 64'(done), 64'd0);
        check_eq("thr_stall_w_beats", 64'(w_cnt), 64'd64);
        b_budget = 1;
        n = 0;
        while ((aw_cnt < 5) && (n < 200)) begin wait_cycles(1); n++; end
        check_eq("thr_fifth_aw", 64'(aw_cnt), 64'd5);
        wait_cycles(40);
        check_eq("thr_one_b", 64'(b_cnt), 64'd1);
        check_eq("thr_not_done", 64'(done), 64'd0);
        b_budget = -1;
        wait_done("throttle", 2000);

        // Error response
        err_inject = 1;
        start_xfer(32'h0000_4000, 8, 4);
        wait_done("error", 500);
        wait_cycles(5);
        check_eq("err_sticky", 64'(err), 64'd1);
        err_inject = 0;
        start_xfer(32'h0000_5000, 4, 4);
        check_eq("err_cleared_on_start", 64'(err), 64'd0);
        wait_done("after_error", 500);

        // Reset in the middle of DATA
        start_xfer(32'h0000_6000, 32, 8);
        n = 0;
        while (!w_valid && (n < 500)) begin wait_cycles(1); n++; end
        check_eq("rst_reached_data", 64'(w_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        #1;
        check_reset_values("mid_rst");

        // Clean transfer after reset, then random configurations
        start_xfer(32'h0000_7000, 24, 8);
        wait_done("post_reset", 1000);

        for (int t = 0; t < 5; t++) begin
            p_s  = 30 + int'($urandom_range(70));
            p_aw = 30 + int'($urandom_range(70));
            p_w  = 30 + int'($urandom_range(70));
            p_b  = 30 + int'($urandom_range(70));
            beats = 1 + int'($urandom_range(99));
            burst = 1 + int'($urandom_range(FIFO_DEPTH - 1));
            base  = $urandom & ~ADDR_W'(BB - 1);
            if (t == 0) base = 32'hFFFF_FFC0;   // forces the address to wrap
            start_xfer(base, beats, burst);
            wait_done($sformatf("random%0d", t), 8000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dg_ddr_writer.md
# dg_ddr_writer

Write-back stage directly downstream of the result/mask formatter (`pe2ddr_dg`). It accepts one `DDR_W`-wide result stream, buffers it in a FIFO and turns it into DDR write bursts (AW/W/B channels) at consecutive addresses from a configured base. It asserts `done` only after every burst has been acknowledged, so the layer controller can start the next layer. One instance serves the `ddr1` result stream and a second serves the `ddr2` mask stream.

## Interface

Parameters:
- `FIFO_DEPTH`, 64: beat buffer depth; power of two, ≥ 2.
- `ADDR_W`, 32: byte-address width.
- `MAX_OUT`, 4: maximum outstanding write responses.
- `BEAT_BYTES`, `DDR_W/8`: address increment per beat. `DDR_W` comes from `GLOBAL_PARAM`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `start`  in  1: one-cycle pulse; latches config and begins a transfer.
- `done`  out  1: high when idle or finished.
- `err`  out  1: sticky; set if any `b_resp` is nonzero, cleared on `start`.
- `conf_base_addr`  in  ADDR_W: first byte address, BEAT_BYTES-aligned.
- `conf_beat_num`  in  16: total beats, ≥ 1.
- `conf_burst_len`  in  8: beats per full burst, 1..min(FIFO_DEPTH,255).
- `s_data`  in  DDR_W: input stream data.
- `s_valid`  in  1: input stream valid.
- `s_ready`  out  1: input stream ready.
- `aw_addr`  out  ADDR_W: burst start address.
- `aw_len`  out  8: beats in burst minus 1.
- `aw_valid`  out  1: address channel valid.
- `aw_ready`  in  1: address channel ready.
- `w_data`  out  DDR_W: write data.
- `w_last`  out  1: marks the last beat of a burst.
- `w_valid`  out  1: write data valid.
- `w_ready`  in  1: write data ready.
- `b_resp`  in  2: write response code.
- `b_valid`  in  1: write response valid.
- `b_ready`  out  1: write response ready.

## Operation

- Config is latched on `start` while `done`=1. A `start` pulse while busy is ignored.
- Input side:
  - `s_ready` = FIFO not full AND accepted count < `conf_beat_num` AND not idle.
  - Beats beyond `conf_beat_num` are never accepted.
- Burst sizing: each burst is `min(conf_burst_len, remaining_beats)`. The final burst may be short.
- FSM:
  - IDLE: `done`=1. On `start`, go to FILL.
  - FILL: wait until FIFO count ≥ current burst length AND outstanding < `MAX_OUT`, then go to ADDR.
  - ADDR: `aw_valid`=1 with `aw_addr`/`aw_len` held stable. On `aw_ready`, go to DATA.
  - DATA: `w_valid`=1, `w_data` = FIFO head (first-word fall-through). Each `w_valid & w_ready` pops one beat. On the last beat of the burst, `w_last`=1.
  - After the last beat of a burst: if bursts remain, advance `aw_addr` by `burst_beats*BEAT_BYTES` and go to FILL; otherwise go to RESP.
  - RESP: wait until outstanding = 0, then go to IDLE, where `done` rises.
- Outstanding counter:
  - +1 on `aw_valid & aw_ready`.
  - −1 on `b_valid & b_ready`.
  - Both events in the same cycle leave it unchanged.
- `b_ready` = 1 in every state except IDLE. A `b_valid` seen in IDLE is not acknowledged.
- Address arithmetic wraps modulo 2^ADDR_W. No 4 KB boundary splitting is performed; bursts are defined by config only.
- `rst` mid-transfer returns to IDLE immediately and flushes the FIFO and all counters. Any in-flight DDR transaction is abandoned.

## Timing

- Reset values: `done`=1, `err`=0, `s_ready`=0, `aw_valid`=0, `w_valid`=0, `w_last`=0, `b_ready`=0, `aw_addr`=0, `aw_len`=0.
- `start` at cycle T: `done`=0 and `s_ready` may be 1 at T+1.
- FIFO write-to-read latency is 1 cycle: a beat accepted at T is visible on `w_data` at T+1.
- FILL→ADDR takes 1 cycle once the condition holds. ADDR→DATA takes the cycle after the `aw_ready` handshake. The first `w_valid` follows the AW handshake by exactly 1 cycle.
- With `w_ready` held high and the FIFO pre-filled, a burst of N beats occupies exactly N cycles in DATA.
- `done` rises the cycle after the final B handshake.
- FIFO full and empty at the same time cannot occur. Simultaneous push and pop leaves the count unchanged. A push when full is blocked by `s_ready`=0.
- All outputs are registered except `w_data` (FIFO head) and `s_ready`.

## Test plan

- Basic transfer: base=0x1000, beats=16, burst=8, all readies high.
  - Expected: two AW at 0x1000 and 0x1000+8·BEAT_BYTES with `aw_len`=7.
  - Expected: 16 W beats in order, `w_last` on beats 8 and 16, `done` after the second B.
- Short tail: beats=10, burst=4.
  - Expected: `aw_len` sequence 3,3,1.
  - Expected: final `w_last` on beat 10; the 11th `s_valid` beat is not accepted.
- Backpressure: random `aw_ready`/`w_ready`/`s_valid` toggling, beats=64, burst=16.
  - Expected: data arrives in order and intact, `aw_addr` stays stable while `aw_valid` is high, and `s_ready` is 0 whenever the FIFO is full.
- Response throttling: `b_valid` withheld, MAX_OUT=4, beats=80, burst=16.
  - Expected: exactly 4 AW issued, then the FSM stalls in FILL.
  - Expected: releasing one B allows the 5th AW; `done` rises only after 5 B.
- Error and reset:
  - One `b_resp`=2 → `err`=1 persists until the next `start`.
  - `rst` asserted mid-DATA → all outputs return to reset values the next cycle.
  - A subsequent `start` performs a clean full transfer.
